digital_clock_mux: RTL and testbench



---
 rtl/digital_clock_pkg.sv | 62 ++++++
 rtl/seg7_decoder.sv | 28 ++
 rtl/digital_clock_mux.sv | 209 ++++++++++++++++++++
 tb/tb_digital_clock_mux.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digital_clock_pkg.sv
// Shared definitions for the digital_clock_mux timekeeper.
//   - SEG_* : active-high 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   - CODE_BLANK : digit code that the decoder renders with all segments off
//   - DIG_* : logical digit positions, 6-digit layout (0 = rightmost)
//   - DIG4_OFFSET : added to the scan index in the 4-digit layout so the
//                   same position map skips the seconds digits
//   - to_12h()    : 24h hour -> 12h display hour (0 -> 12, 13..23 -> 1..11)
//   - bcd_split() : 0..59 -> {tens, units}
package digital_clock_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam logic [2:0] DIG_SEC_U = 3'd0;
    localparam logic [2:0] DIG_SEC_T = 3'd1;
    localparam logic [2:0] DIG_MIN_U = 3'd2;
    localparam logic [2:0] DIG_MIN_T = 3'd3;
    localparam logic [2:0] DIG_HR_U  = 3'd4;
    localparam logic [2:0] DIG_HR_T  = 3'd5;

    localparam logic [2:0] DIG4_OFFSET = 3'd2;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_t;

    function automatic logic [4:0] to_12h(input logic [4:0] hour);
        if (hour == 5'd0) begin
            return 5'd12;
        end
        if (hour > 5'd12) begin
            return hour - 5'd12;
        end
        return hour;
    endfunction

    // Comparison chain instead of a divider: the input never exceeds 59.
    function automatic bcd_t bcd_split(input logic [5:0] value);
        bcd_t r;
        if (value >= 6'd50)      r.tens = 4'd5;
        else if (value >= 6'd40) r.tens = 4'd4;
        else if (value >= 6'd30) r.tens = 4'd3;
        else if (value >= 6'd20) r.tens = 4'd2;
        else if (value >= 6'd10) r.tens = 4'd1;
        else                     r.tens = 4'd0;
        r.units = 4'(value - 6'(r.tens) * 6'd10);
        return r;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational digit-code to 7-segment decoder.
//   code : 4-bit digit code, 0..9 or CODE_BLANK (any other value also blanks)
//   seg  : active-high segments {g,f,e,d,c,b,a}
module seg7_decoder
    import digital_clock_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/digital_clock_mux.sv
// Hours/minutes/seconds timekeeper with a time-multiplexed 7-segment display.
// Time is kept internally in 24h form; 12h conversion is display-only.
//
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   en         : count enable (0 freezes time, scanning continues)
//   mode_24h   : 1 = 24h display, 0 = 12h display with blanked leading zero
//   inc_hr     : async button, hours +1 mod 24
//   inc_min    : async button, minutes +1 mod 60 (no carry)
//   clr_sec    : async button, seconds and prescaler cleared
//   seg, dp    : registered segments {g,f,e,d,c,b,a} and colon/decimal point
//   dig_en     : registered one-hot digit enable, bit 0 = rightmost digit
//   pm         : registered, hour >= 12 (independent of display mode)
//   sec_tick   : one-cycle pulse in the cycle the prescaler wraps; the time
//                counters take the new second at the end of that cycle
module digital_clock_mux
    import digital_clock_pkg::*;
#(
    parameter int CLK_HZ         = 10000000,
    parameter int SCAN_DIV       = 10000,
    parameter int NUM_DIGITS     = 6,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode_24h,
    input  logic                  inc_hr,
    input  logic                  inc_min,
    input  logic                  clr_sec,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  pm,
    output logic                  sec_tick
);

    localparam int PRESC_W = $clog2(CLK_HZ);
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);
    localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------
    // Button synchronisers: [0] and [1] are the 2-flop synchroniser, [2]
    // is the previous synchronised value for rising-edge detection.
    // ------------------------------------------------------------------
    logic [2:0] hr_sync;
    logic [2:0] min_sync;
    logic [2:0] clr_sync;
    logic       hr_pulse;
    logic       min_pulse;
    logic       clr_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hr_sync  <= '0;
            min_sync <= '0;
            clr_sync <= '0;
        end else begin
            hr_sync  <= {hr_sync[1:0], inc_hr};
            min_sync <= {min_sync[1:0], inc_min};
            clr_sync <= {clr_sync[1:0], clr_sec};
        end
    end

    assign hr_pulse  = hr_sync[1]  & ~hr_sync[2];
    assign min_pulse = min_sync[1] & ~min_sync[2];
    assign clr_pulse = clr_sync[1] & ~clr_sync[2];

    // ------------------------------------------------------------------
    // Prescaler and time counters
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_q;
    logic [5:0]         sec_q;
    logic [5:0]         min_q;
    logic [4:0]         hr_q;
    logic               presc_wrap;
    logic               tick;
    logic               sec_wrap;
    logic               min_wrap;

    assign presc_wrap = en && (presc_q == PRESC_MAX);
    // A clear landing on the wrap cycle wins: no second is counted.
    assign tick       = presc_wrap && !clr_pulse;
    assign sec_tick   = tick;
    assign sec_wrap   = tick && (sec_q == 6'd59);
    // A manual minute step replaces the carry into minutes, so it also
    // cannot produce a carry into hours.
    assign min_wrap   = sec_wrap && !min_pulse && (min_q == 6'd59);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hr_q    <= '0;
            pm      <= 1'b0;
        end else begin
            if (clr_pulse || presc_wrap) begin
                presc_q <= '0;
            end else if (en) begin
                presc_q <= presc_q + 1'b1;
            end

            if (clr_pulse) begin
                sec_q <= '0;
            end else if (tick) begin
                sec_q <= (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
            end

            // Increment and carry merge into a single +1.
            if (min_pulse || sec_wrap) begin
                min_q <= (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            end

            if (hr_pulse || min_wrap) begin
                hr_q <= (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
            end

            pm <= (hr_q >= 5'd12);
        end
    end

    // ------------------------------------------------------------------
    // Scan counter and digit index
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0] scan_cnt_q;
    logic [IDX_W-1:0]  idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
        end else if (scan_cnt_q == SCAN_MAX) begin
            scan_cnt_q <= '0;
            idx_q      <= (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Digit selection
    // ------------------------------------------------------------------
    logic [4:0]            hr_disp;
    bcd_t                  hr_bcd;
    bcd_t                  min_bcd;
    bcd_t                  sec_bcd;
    logic [2:0]            pos;
    logic [3:0]            code;
    logic                  dp_raw;
    logic [NUM_DIGITS-1:0] dig_raw;
    logic [6:0]            seg_raw;

    always_comb begin
        hr_disp = mode_24h ? hr_q : to_12h(hr_q);
        hr_bcd  = bcd_split({1'b0, hr_disp});
        min_bcd = bcd_split(min_q);
        sec_bcd = bcd_split(sec_q);
        // The 4-digit layout is the 6-digit layout shifted past the seconds.
        pos     = 3'(idx_q) + ((NUM_DIGITS == 4) ? DIG4_OFFSET : 3'd0);
        code    = CODE_BLANK;
        dp_raw  = 1'b0;
        case (pos)
            DIG_SEC_U: code = sec_bcd.units;
            DIG_SEC_T: code = sec_bcd.tens;
            DIG_MIN_U: begin
                code   = min_bcd.units;
                dp_raw = (NUM_DIGITS == 6) && !sec_q[0];
            end
            DIG_MIN_T: code = min_bcd.tens;
            DIG_HR_U: begin
                code   = hr_bcd.units;
                dp_raw = !sec_q[0];
            end
            DIG_HR_T: begin
                code = (!mode_24h && (hr_bcd.tens == 4'd0)) ? CODE_BLANK : hr_bcd.tens;
            end
            default: code = CODE_BLANK;
        endcase
        // First cycle of each slot keeps every digit off to avoid ghosting.
        dig_raw = (scan_cnt_q == '0) ? '0 : (NUM_DIGITS'(1) << idx_q);
    end

    seg7_decoder u_dec (
        .code (code),
        .seg  (seg_raw)
    );

    // ------------------------------------------------------------------
    // Output registers with polarity applied
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg    <= {7{SEG_ACTIVE_LOW}};
            dp     <= SEG_ACTIVE_LOW;
            dig_en <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
        end else begin
            seg    <= seg_raw ^ {7{SEG_ACTIVE_LOW}};
            dp     <= dp_raw ^ SEG_ACTIVE_LOW;
            dig_en <= dig_raw ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_digital_clock_mux.sv
// Directed bench for digital_clock_mux (CLK_HZ=4, SCAN_DIV=4, 6 digits).
// Stimulus pushes expected values into a queue; a negedge monitor pops
// and compares. A second instance with inverted polarities runs in
// lock-step and is checked every cycle for an exact complement.
module tb_digital_clock_mux;

    localparam int CLK_HZ     = 4;
    localparam int SCAN_DIV   = 4;
    localparam int NUM_DIGITS = 6;

    // ---------------- clock / reset ----------------
    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic en       = 1'b0;
    logic mode_24h = 1'b1;
    logic inc_hr   = 1'b0;
    logic inc_min  = 1'b0;
    logic clr_sec  = 1'b0;

    logic [6:0] seg, seg_i;
    logic       dp, dp_i;
    logic [5:0] dig_en, dig_en_i;
    logic       pm, pm_i;
    logic       sec_tick, sec_tick_i;

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    digital_clock_mux #(
        .CLK_HZ(CLK_HZ), .SCAN_DIV(SCAN_DIV), .NUM_DIGITS(NUM_DIGITS),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode_24h(mode_24h),
        .inc_hr(inc_hr), .inc_min(inc_min), .clr_sec(clr_sec),
        .seg(seg), .dp(dp), .dig_en(dig_en), .pm(pm), .sec_tick(sec_tick)
    );

    digital_clock_mux #(
        .CLK_HZ(CLK_HZ), .SCAN_DIV(SCAN_DIV), .NUM_DIGITS(NUM_DIGITS),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut_inv (
        .clk(clk), .rst_n(rst_n), .en(en), .mode_24h(mode_24h),
        .inc_hr(inc_hr), .inc_min(inc_min), .clr_sec(clr_sec),
        .seg(seg_i), .dp(dp_i), .dig_en(dig_en_i), .pm(pm_i), .sec_tick(sec_tick_i)
    );

    // ---------------- scoreboard ----------------
    typedef enum int {K_SEG, K_DP, K_DIGEN, K_PM, K_TICKS, K_TICK_RST, K_TIME, K_PRESC} kind_t;

    logic [31:0] exp_q[$];
    kind_t       kind_q[$];
    string       name_q[$];

    int n_tests  = 0;
    int n_fail   = 0;
    int tick_cnt = 0;

    task automatic push_exp(input kind_t k, input logic [31:0] v, input string name);
        kind_q.push_back(k);
        exp_q.push_back(v);
        name_q.push_back(name);
    endtask

    // Time is read as decimal HHMMSS for readable messages.
    function automatic logic [31:0] actual(input kind_t k);
        case (k)
            K_SEG:   return 32'(seg);
            K_DP:    return 32'(dp);
            K_DIGEN: return 32'(dig_en);
            K_PM:    return 32'(pm);
            K_TICKS: return 32'(tick_cnt);
            K_TIME:  return 32'(dut.hr_q) * 32'd10000 + 32'(dut.min_q) * 32'd100 + 32'(dut.sec_q);
            K_PRESC: return 32'(dut.presc_q);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(negedge clk) begin
        if (sec_tick === 1'b1) tick_cnt++;
        n_tests++;
        if ({seg_i, dp_i, dig_en_i, pm_i, sec_tick_i} !== {~seg, ~dp, ~dig_en, pm, sec_tick}) begin
            n_fail++;
            $display("FAIL polarity_twin @%0t: got %h, want %h", $time,
                     {seg_i, dp_i, dig_en_i, pm_i, sec_tick_i}, {~seg, ~dp, ~dig_en, pm, sec_tick});
        end
        while (exp_q.size() > 0) begin
            kind_t       k;
            logic [31:0] e;
            logic [31:0] a;
            string       nm;
            k  = kind_q.pop_front();
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (k == K_TICK_RST) begin
                tick_cnt = 0;
            end else begin
                a = actual(k);
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got %0d (0x%0h), want %0d (0x%0h)", nm, $time, a, a, e, e);
                end
                if (k == K_TICKS) tick_cnt = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Every task returns 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        en = 1'b1;
        step(n);
        en = 1'b0;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       inc_hr  = v;
            1:       inc_min = v;
            default: clr_sec = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        step(2);
        set_btn(b, 1'b0);
        step(2);
    endtask

    task automatic wait_dig(input logic [5:0] v, input string name);
        int c;
        c = 0;
        while (dig_en !== v && c < 40) begin
            step(1);
            c++;
        end
        if (dig_en !== v) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: got %h, want %h", name, dig_en, v);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        step(3);
        push_exp(K_SEG,   0, "reset_seg");
        push_exp(K_DP,    0, "reset_dp");
        push_exp(K_DIGEN, 0, "reset_dig_en");
        push_exp(K_PM,    0, "reset_pm");
        push_exp(K_TIME,  0, "reset_time");
        push_exp(K_PRESC, 0, "reset_presc");
        push_exp(K_TICKS, 0, "reset_sec_tick");

        // Reset and count: 240 cycles -> 60 ticks, 00:01:00
        rst_n = 1'b1;
        push_exp(K_TICK_RST, 0, "");
        run(240);
        push_exp(K_TICKS, 60, "count_ticks");
        push_exp(K_TIME,  100, "count_time");
        push_exp(K_PM,    0, "count_pm");
        push_exp(K_PRESC, 0, "count_presc");

        // Set 23:59:59; minute press also checks the 3-cycle latency
        repeat (23) press(0);
        push_exp(K_TIME, 230100, "set_hr23");
        inc_min = 1'b1;
        step(2);
        inc_min = 1'b0;
        push_exp(K_TIME, 230100, "latency_before");
        step(1);
        push_exp(K_TIME, 230200, "latency_at3");
        step(1);
        repeat (57) press(1);
        run(236);
        push_exp(K_TIME,  235959, "set_235959");
        push_exp(K_PRESC, 0, "set_presc");
        push_exp(K_PM,    1, "pm_at_23");

        // Midnight rollover, 12h display of hour 0 as 12
        mode_24h = 1'b0;
        push_exp(K_TICK_RST, 0, "");
        run(4);
        push_exp(K_TIME,  0, "midnight_time");
        push_exp(K_TICKS, 1, "midnight_one_tick");
        step(1);
        push_exp(K_PM, 0, "midnight_pm");
        wait_dig(6'h20, "wait_hr_t");
        push_exp(K_SEG, 32'h06, "mid12_hr_tens");
        wait_dig(6'h10, "wait_hr_u");
        push_exp(K_SEG, 32'h5B, "mid12_hr_units");
        push_exp(K_DP,  1, "mid12_dp_hr_u");
        wait_dig(6'h08, "wait_min_t");
        push_exp(K_SEG, 32'h3F, "mid12_min_tens");
        wait_dig(6'h01, "wait_sec_u");
        push_exp(K_SEG, 32'h3F, "mid12_sec_units");

        // Hour 13: 12h then 24h
        repeat (13) press(0);
        push_exp(K_PM, 1, "h13_pm");
        wait_dig(6'h20, "wait_hr_t");
        push_exp(K_SEG, 32'h00, "h13_12h_tens_blank");
        wait_dig(6'h10, "wait_hr_u");
        push_exp(K_SEG, 32'h06, "h13_12h_units");
        mode_24h = 1'b1;
        step(1);
        wait_dig(6'h20, "wait_hr_t");
        push_exp(K_SEG, 32'h06, "h13_24h_tens");
        wait_dig(6'h10, "wait_hr_u");
        push_exp(K_SEG, 32'h4F, "h13_24h_units");

        // Scan order and anti-ghost gap (seconds = 0, even)
        wait_dig(6'h20, "scan_sync_last");
        wait_dig(6'h00, "scan_sync_gap");
        for (int i = 0; i < 6; i++) begin
            push_exp(K_DIGEN, 0, "scan_gap");
            step(1);
            for (int j = 0; j < 3; j++) begin
                push_exp(K_DIGEN, 32'(1 << i), "scan_onehot");
                push_exp(K_DP, (i == 4 || i == 2) ? 1 : 0, "scan_dp_even");
                step(1);
            end
        end

        // Odd second: colon off
        run(4);
        push_exp(K_TIME, 130001, "odd_time");
        step(1);
        wait_dig(6'h10, "wait_hr_u");
        push_exp(K_SEG, 32'h4F, "odd_hr_units");
        push_exp(K_DP,  0, "odd_dp_hr_u");
        wait_dig(6'h04, "wait_min_u");
        push_exp(K_DP,  0, "odd_dp_min_u");
        wait_dig(6'h01, "wait_sec_u");
        push_exp(K_SEG, 32'h06, "odd_sec_units");

        // inc_min pulse on the same cycle as the 59 -> 0 carry
        run(232);
        push_exp(K_TIME, 130059, "pre_carry_time");
        en = 1'b1;
        step(1);
        inc_min = 1'b1;
        step(2);
        inc_min = 1'b0;
        step(1);
        en = 1'b0;
        push_exp(K_TIME, 130100, "inc_min_vs_carry");

        // clr_sec on the prescaler wrap cycle: no tick
        push_exp(K_TICK_RST, 0, "");
        en = 1'b1;
        step(1);
        clr_sec = 1'b1;
        step(2);
        clr_sec = 1'b0;
        step(1);
        en = 1'b0;
        push_exp(K_TICKS, 0, "clr_vs_wrap_ticks");
        push_exp(K_TIME,  130100, "clr_vs_wrap_time");
        push_exp(K_PRESC, 0, "clr_vs_wrap_presc");

        // clr_sec mid-count clears the prescaler
        run(2);
        press(2);
        push_exp(K_PRESC, 0, "clr_presc");
        run(3);
        push_exp(K_TIME,  130100, "after_clr_time");
        push_exp(K_PRESC, 3, "after_clr_presc");

        // Freeze: time and prescaler hold, scanning continues
        push_exp(K_TICK_RST, 0, "");
        wait_dig(6'h08, "wait_min_t");
        push_exp(K_SEG, 32'h3F, "freeze_min_tens");
        wait_dig(6'h04, "wait_min_u");
        push_exp(K_SEG, 32'h06, "freeze_min_units");
        push_exp(K_DP,  1, "freeze_dp_min_u");
        step(100);
        push_exp(K_TIME,  130100, "freeze_time");
        push_exp(K_PRESC, 3, "freeze_presc");
        push_exp(K_TICKS, 0, "freeze_ticks");

        // Reset mid-slot: outputs inactive immediately
        wait_dig(6'h02, "wait_sec_t");
        rst_n = 1'b0;
        push_exp(K_SEG,   0, "midrst_seg");
        push_exp(K_DP,    0, "midrst_dp");
        push_exp(K_DIGEN, 0, "midrst_dig_en");
        push_exp(K_PM,    0, "midrst_pm");
        push_exp(K_TIME,  0, "midrst_time");
        push_exp(K_PRESC, 0, "midrst_presc");
        step(2);
        rst_n = 1'b1;
        step(2);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
